// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline-stage register carrying a data payload
// and a control payload between two pipeline stages.
//
// Build option: define PIPE_SKID_EN for a two-entry skid buffer with a
// registered in_ready. Leave it undefined for a single-entry register with a
// combinational in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of held and incoming beats
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat
//   in_data    upstream data payload  [DATA_W]
//   in_ctrl    upstream control payload [CTRL_W]
//   out_valid  beat available downstream
//   out_ready  downstream accepts (low = stall)
//   out_data   head data payload [DATA_W]
//   out_ctrl   head control, or CTRL_RST when out_valid=0 [CTRL_W]
//   occupancy  number of entries held (0..1, or 0..2 with skid buffer)
module pipe_stage_reg #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
  parameter bit                 DATA_CLR = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              in_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign out_data = head_data;

  // Bubbles present the safe control value so no write can leak downstream.
  assign out_ctrl = out_valid ? head_ctrl : CTRL_RST;

`ifdef PIPE_SKID_EN

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              load_head_in;
  logic              load_head_skid;
  logic              load_skid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // State register plus the registered handshake/status outputs derived
  // from the next state, so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != S_TWO);
      out_valid <= (state_d != S_EMPTY);
      occupancy <= 2'(state_d);
    end
  end

  // Next-state and storage-load decode; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d      = S_ONE;
            load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            load_head_in = 1'b1;
          end else if (in_xfer) begin
            state_d   = S_TWO;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_xfer) begin
            state_d        = S_ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Payload storage for head and skid entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      skid_data <= '0;
      head_ctrl <= CTRL_RST;
      skid_ctrl <= CTRL_RST;
    end else if (flush) begin
      if (DATA_CLR) begin
        head_data <= '0;
        skid_data <= '0;
      end
      head_ctrl <= CTRL_RST;
      skid_ctrl <= CTRL_RST;
    end else begin
      if (load_head_in) begin
        head_data <= in_data;
        head_ctrl <= in_ctrl;
      end else if (load_head_skid) begin
        head_data <= skid_data;
        head_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`else

  logic valid_d;

  // Single entry: accept when empty or when the head leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  // Next valid; flush discards any incoming beat.
  always_comb begin
    valid_d = out_valid;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_xfer) begin
      valid_d = 1'b1;
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end

  // Valid/occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      out_valid <= valid_d;
      occupancy <= {1'b0, valid_d};
    end
  end

  // Payload storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_ctrl <= CTRL_RST;
    end else if (flush) begin
      if (DATA_CLR) begin
        head_data <= '0;
      end
      head_ctrl <= CTRL_RST;
    end else if (in_xfer) begin
      head_data <= in_data;
      head_ctrl <= in_ctrl;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against
// a queue-based model of an in-order buffer with capacity 1 (or 2 with
// PIPE_SKID_EN).
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
`ifdef PIPE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t mq[$];
  int    checks = 0;
  int    passed = 0;
  int    dut_deliv = 0;
  int    mdl_deliv = 0;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .CTRL_RST (16'h0000),
    .DATA_CLR (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, compare against the model, then apply
  // the transfers the model expects at the following rising edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl, output logic acc);
    logic          ev;
    logic          er;
    logic [CW-1:0] ec;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    ev = (mq.size() > 0);
    if (CAP == 2) er = (mq.size() < 2);
    else          er = (mq.size() == 0) || ordy;
    ec = ev ? mq[0].c : 16'h0000;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("out_ctrl", 32'(out_ctrl), 32'(ec));
    if (ev) chk("out_data", out_data, mq[0].d);
    if (out_valid && ordy) dut_deliv++;
    acc = iv && er;
    @(posedge clk);
    if (ev && ordy) begin
      void'(mq.pop_front());
      mdl_deliv++;
    end
    if (fl) mq.delete();
    else if (acc) mq.push_back('{d: d, c: c});
  endtask

  initial begin
    logic          acc;
    logic [DW-1:0] stall_d [3];
    int            cyc;

    stall_d[0] = 32'hA0;
    stall_d[1] = 32'hA1;
    stall_d[2] = 32'hA2;

    // Power-on reset.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h1000 + 32'(i), 16'(i + 1), 1'b1, 1'b0, acc);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Stall: out_ready low for three cycles after A0 is presented.
    cyc = 0;
    for (int b = 0; b < 3; b++) begin
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
        step(1'b1, stall_d[b], 16'(b + 16'h20), !(cyc >= 1 && cyc <= 3), 1'b0, acc);
        cyc++;
      end
      chk("stall_accept", 32'(acc), 32'd1);
    end
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Flush while full with an incoming control beat 0x0013.
    step(1'b1, 32'h55, 16'h0005, 1'b0, 1'b0, acc);
    step(1'b1, 32'h56, 16'h0006, 1'b0, 1'b0, acc);
    step(1'b1, 32'h77, 16'h0013, 1'b0, 1'b1, acc);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Flush coinciding with an output handshake.
    step(1'b1, 32'h88, 16'h0008, 1'b0, 1'b0, acc);
    step(1'b1, 32'h99, 16'h0009, 1'b1, 1'b1, acc);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Bubble gating with all-ones control on the idle input.
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'($urandom()), 16'hFFFF, 1'($urandom_range(0, 1)), 1'b0, acc);

    // Asynchronous reset mid-cycle while one entry is held.
    step(1'b1, 32'hBEEF, 16'h00AA, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("pre_rst_occ", 32'(occupancy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'h0000);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 32'($urandom()), 16'($urandom()),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), acc);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    chk("deliv_count", 32'(dut_deliv), 32'(mdl_deliv));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline-stage register that generalises the fixed ID/EX latch. It carries separate data and control payloads between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) using valid/ready flow control instead of a bare stall input. It provides a synchronous flush that forces bubble-safe control values, and an optional two-entry skid buffer that registers the upstream ready.

## Interface
Parameters:
- DATA_W, 32: data payload width (operands, PC, immediate, register indices); must be ≥1
- CTRL_W, 16: control payload width (regWrite, memWrite, resultSrc, ...); must be ≥1
- CTRL_RST, '0: control value presented whenever out_valid=0 and loaded on reset/flush
- DATA_CLR, 0: 1 = data storage zeroed on reset/flush; 0 = data storage retained (don't-care)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  DATA_W  upstream data payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  beat available downstream
- out_ready  in  1  downstream accepts; low = stall
- out_data  out  DATA_W  data payload of head entry
- out_ctrl  out  CTRL_W  head control, or CTRL_RST when out_valid=0
- occupancy  out  2  entries held: 0..1 without skid buffer, 0..2 with it

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Beats leave in arrival order; no beat is duplicated or dropped except by flush.
- out_ctrl is gated: it equals CTRL_RST whenever out_valid=0, so a bubble can never assert writes downstream.
- The stall equivalent is out_ready=0: the head entry and its payload hold stable while out_valid=1. This is required.
- Flush is synchronous and has priority over input and output transfers:
  - An output transfer in the flush cycle still completes.
  - Every other held entry and any input beat in that cycle are discarded.
  - The next cycle shows out_valid=0, occupancy=0, out_ctrl=CTRL_RST. Data is zeroed only if DATA_CLR=1.
- Skid state machine (PIPE_SKID_EN), with entries head and skid:
  - EMPTY → ONE on input transfer.
  - ONE → TWO on input transfer without output transfer.
  - ONE → EMPTY on output transfer without input transfer.
  - ONE stays ONE when both transfers occur; head is replaced.
  - TWO → ONE on output transfer; skid moves to head.
  - TWO holds when there is no output transfer.
  - flush → EMPTY from any state.
- in_ready = (state != TWO), driven from a register. It has no combinational path from out_ready.
- Without skid: single entry; in_ready = !out_valid || out_ready (combinational).
- Reset (rst_n low, asynchronous, including mid-transfer): out_valid=0, occupancy=0, out_ctrl=CTRL_RST, in_ready=1. out_data=0 if DATA_CLR=1, else unspecified.

## Timing
- Latency from input transfer to out_valid: 1 cycle when EMPTY, or when ONE with a simultaneous output transfer.
- Throughput: 1 beat/cycle sustained with out_ready held high, in both configurations.
- With skid: after out_ready falls, one further beat is accepted (ONE → TWO), then in_ready=0 from the next cycle. in_ready returns to 1 the cycle after the first output transfer out of TWO.
- Flush takes effect at the edge where it is sampled. in_ready=1 the following cycle.
- out_valid and out_data come from registers in both configurations; out_ctrl passes through one AND/mux level only.

## Configuration
- PIPE_SKID_EN defined: two-entry skid buffer, registered in_ready, occupancy up to 2. Breaks the out_ready→in_ready timing path across a stall chain.
- PIPE_SKID_EN undefined: single-entry register, combinational in_ready, occupancy up to 1, minimum area.

## Test plan
- Reset: rst_n=0 asserted mid-cycle with occupancy=1 → out_valid=0 immediately, out_ctrl=CTRL_RST=0x0000, in_ready=1, occupancy=0.
- Streaming: out_ready=1, in_valid=1, in_data=0x1000..0x1007 over 8 cycles → identical sequence on out_data, one per cycle, starting 1 cycle later, with no gaps.
- Stall: with PIPE_SKID_EN, stream 0xA0, 0xA1, 0xA2 and drop out_ready after 0xA0 is presented → 0xA1 accepted, in_ready=0, occupancy=2, out_data held at 0xA0. Raise out_ready → 0xA0, 0xA1, 0xA2 delivered in order. Without PIPE_SKID_EN, in_ready=0 in the same cycle out_ready=0.
- Flush: in state TWO with in_valid=1, in_ctrl=0x0013, assert flush for one cycle → next cycle out_valid=0, out_ctrl=0x0000, occupancy=0; the 0x0013 beat never appears at the output.
- Flush with output handshake: out_valid=1, out_ready=1, flush=1 in the same cycle → the head beat counts as delivered exactly once, and nothing else is delivered afterwards.
- Bubble gating: in_valid=0 for 3 cycles while in_ctrl=0xFFFF → out_ctrl=0x0000 throughout, and no out_valid pulse.
